// File: rtl/brick_game_sequencer_if.sv
// brick_game_sequencer_if: ball-motion and brick-store handshake bundle seen by the game sequencer.
interface brick_game_sequencer_if;
    logic [3:0] ball_row;
    logic [3:0] ball_col;
    logic       ball_step;
    logic       ball_done;
    logic       ball_miss;
    logic       ball_reload;
    logic       brick_req;
    logic [3:0] brick_row;
    logic [3:0] brick_col;
    logic       brick_ack;
    logic       brick_hit;
    logic       brick_reload;
    modport master (
        output ball_step, ball_reload, brick_req, brick_row, brick_col, brick_reload,
        input  ball_row, ball_col, ball_done, ball_miss, brick_ack, brick_hit
    );
    modport slave (
        input  ball_step, ball_reload, brick_req, brick_row, brick_col, brick_reload,
        output ball_row, ball_col, ball_done, ball_miss, brick_ack, brick_hit
    );
endinterface

// File: rtl/brick_game_sequencer.sv
// brick_game_sequencer: game tick, ball stepping, brick collision lookup and score/lives bookkeeping.
module brick_game_sequencer #(
    parameter int TICK_DIV    = 25000000,
    parameter int LIVES       = 3,
    parameter int BRICK_ROWS  = 7,
    parameter int BRICK_COUNT = 56
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    brick_game_sequencer_if.master      bus,
    output logic [9:0]                  score,
    output logic [1:0]                  lives,
    output logic [1:0]                  game_state
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BRICK_COUNT + 1);
    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BRICKS_INIT = BW'(BRICK_COUNT);
    localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
    localparam logic [4:0]    ROWS        = 5'(BRICK_ROWS);

    localparam logic [2:0] S_SERVE     = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_STEP      = 3'd2;
    localparam logic [2:0] S_WAIT_BALL = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_WON       = 3'd5;
    localparam logic [2:0] S_LOST      = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bricks_left;

    always_comb
        game_state = (state == S_SERVE) ? 2'd0 :
                     (state == S_WON)   ? 2'd2 :
                     (state == S_LOST)  ? 2'd3 : 2'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_SERVE;
            cnt              <= '0;
            score            <= '0;
            lives            <= LIVES_INIT;
            bricks_left      <= BRICKS_INIT;
            bus.ball_step    <= 1'b0;
            bus.ball_reload  <= 1'b0;
            bus.brick_reload <= 1'b0;
            bus.brick_req    <= 1'b0;
            bus.brick_row    <= '0;
            bus.brick_col    <= '0;
        end else begin
            bus.ball_step    <= 1'b0;
            bus.ball_reload  <= 1'b0;
            bus.brick_reload <= 1'b0;
            case (state)
                S_SERVE:
                    if (start) begin
                        state <= S_WAIT_TICK;
                        cnt   <= '0;
                    end
                // ball_step is raised on the edge entering STEP so it spans exactly that state
                S_WAIT_TICK:
                    if (cnt == TICK_LAST) begin
                        cnt           <= '0;
                        state         <= S_STEP;
                        bus.ball_step <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                S_STEP:
                    state <= S_WAIT_BALL;
                S_WAIT_BALL:
                    if (bus.ball_done) begin
                        if (bus.ball_miss) begin
                            lives <= lives - 1'b1;
                            if (lives == 2'd1) begin
                                state <= S_LOST;
                            end else begin
                                bus.ball_reload <= 1'b1;
                                state           <= S_SERVE;
                            end
                        end else if ({1'b0, bus.ball_row} < ROWS) begin
                            bus.brick_row <= bus.ball_row;
                            bus.brick_col <= bus.ball_col;
                            bus.brick_req <= 1'b1;
                            state         <= S_CHECK;
                        end else begin
                            state <= S_WAIT_TICK;
                        end
                    end
                S_CHECK:
                    if (bus.brick_ack) begin
                        bus.brick_req <= 1'b0;
                        if (bus.brick_hit) begin
                            score       <= (score == 10'h3ff) ? score : score + 1'b1;
                            bricks_left <= (bricks_left == '0) ? bricks_left : bricks_left - 1'b1;
                            state       <= (bricks_left <= BW'(1)) ? S_WON : S_WAIT_TICK;
                        end else begin
                            state <= S_WAIT_TICK;
                        end
                    end
                S_WON, S_LOST:
                    if (start) begin
                        bus.brick_reload <= 1'b1;
                        bus.ball_reload  <= 1'b1;
                        score            <= '0;
                        lives            <= LIVES_INIT;
                        bricks_left      <= BRICKS_INIT;
                        state            <= S_SERVE;
                    end
                default:
                    state <= S_SERVE;
            endcase
        end
    end
endmodule

// File: tb/tb_brick_game_sequencer.sv
// tb_brick_game_sequencer: randomized scenario tests against a score/lives/bricks reference model.
module tb_brick_game_sequencer;
    localparam int TICK_DIV    = 4;
    localparam int LIVES       = 3;
    localparam int BRICK_ROWS  = 7;
    localparam int BRICK_COUNT = 56;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] score;
    logic [1:0] lives;
    logic [1:0] game_state;

    int nchecks = 0;
    int nerrors = 0;
    int m_score, m_lives, m_bricks, m_state;

    brick_game_sequencer_if bus ();

    brick_game_sequencer #(
        .TICK_DIV(TICK_DIV), .LIVES(LIVES), .BRICK_ROWS(BRICK_ROWS), .BRICK_COUNT(BRICK_COUNT)
    ) dut (
        .clock(clk), .reset(rst), .start(start), .bus(bus.master),
        .score(score), .lives(lives), .game_state(game_state)
    );

    always #5 clk = ~clk;

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ball_step && n <= 50);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic ball_move(input int r, input int c, input logic m);
        @(negedge clk);
        bus.ball_row  = 4'(r);
        bus.ball_col  = 4'(c);
        bus.ball_miss = m;
        bus.ball_done = 1'b1;
        @(negedge clk);
        bus.ball_done = 1'b0;
        bus.ball_miss = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_score = 0; m_lives = LIVES; m_bricks = BRICK_COUNT; m_state = 0;
        nchecks++;
        if ({game_state, score, lives} !== {2'(m_state), 10'(m_score), 2'(m_lives)}) begin
            nerrors++;
            $display("FAIL reset_counters: state=%0d score=%0d lives=%0d, want 0 0 3", game_state, score, lives);
        end
        nchecks++;
        if ({bus.ball_step, bus.ball_reload, bus.brick_reload, bus.brick_req, bus.brick_row, bus.brick_col} !== 12'd0) begin
            nerrors++;
            $display("FAIL reset_outputs: step=%b reload=%b brel=%b req=%b row=%0d col=%0d, want all 0",
                     bus.ball_step, bus.ball_reload, bus.brick_reload, bus.brick_req, bus.brick_row, bus.brick_col);
        end
        repeat (6) @(negedge clk);
        nchecks++;
        if (game_state !== 2'd0 || bus.ball_step !== 1'b0) begin
            nerrors++;
            $display("FAIL idle_serve: state=%0d step=%b, want 0 0", game_state, bus.ball_step);
        end
    endtask

    task automatic test_first_tick;
        int n;
        pulse_start;
        m_state = 1;
        nchecks++;
        if (game_state !== 2'(m_state)) begin
            nerrors++;
            $display("FAIL start_play: state=%0d, want %0d", game_state, m_state);
        end
        wait_step(n);
        nchecks++;
        if (n !== TICK_DIV) begin
            nerrors++;
            $display("FAIL first_tick: step after %0d cycles, want %0d", n, TICK_DIV);
        end
        @(negedge clk);
        nchecks++;
        if (bus.ball_step !== 1'b0) begin
            nerrors++;
            $display("FAIL step_width: step=%b on second cycle, want 0", bus.ball_step);
        end
        ball_move(2, 5, 1'b0);
        nchecks++;
        if ({bus.brick_req, bus.brick_row, bus.brick_col} !== {1'b1, 4'd2, 4'd5}) begin
            nerrors++;
            $display("FAIL lookup_req: req=%b row=%0d col=%0d, want 1 2 5", bus.brick_req, bus.brick_row, bus.brick_col);
        end
        for (int i = 0; i < 5; i++) begin
            bus.ball_row = 4'($urandom_range(0, 15));
            bus.ball_col = 4'($urandom_range(0, 15));
            @(negedge clk);
            nchecks++;
            if ({bus.brick_req, bus.brick_row, bus.brick_col} !== {1'b1, 4'd2, 4'd5}) begin
                nerrors++;
                $display("FAIL req_hold: cycle %0d req=%b row=%0d col=%0d, want 1 2 5", i, bus.brick_req, bus.brick_row, bus.brick_col);
            end
        end
        bus.brick_ack = 1'b1; bus.brick_hit = 1'b1;
        @(negedge clk);
        bus.brick_ack = 1'b0; bus.brick_hit = 1'b0;
        m_score++; m_bricks--;
        nchecks++;
        if (bus.brick_req !== 1'b0 || score !== 10'(m_score)) begin
            nerrors++;
            $display("FAIL ack_hit: req=%b score=%0d, want 0 %0d", bus.brick_req, score, m_score);
        end
    endtask

    task automatic test_no_lookup;
        int n;
        wait_step(n);
        nchecks++;
        if (n !== TICK_DIV) begin
            nerrors++;
            $display("FAIL tick_after_ack: step after %0d cycles, want %0d", n, TICK_DIV);
        end
        ball_move(9, 3, 1'b0);
        nchecks++;
        if (bus.brick_req !== 1'b0 || game_state !== 2'd1) begin
            nerrors++;
            $display("FAIL row_out_of_field: req=%b state=%0d, want 0 1", bus.brick_req, game_state);
        end
        wait_step(n);
        nchecks++;
        if (n !== TICK_DIV) begin
            nerrors++;
            $display("FAIL tick_after_no_lookup: step after %0d cycles, want %0d", n, TICK_DIV);
        end
    endtask

    task automatic test_miss;
        int n;
        for (int k = 0; k < LIVES; k++) begin
            if (k > 0) begin
                pulse_start;
                wait_step(n);
            end
            ball_move($urandom_range(0, 15), $urandom_range(0, 15), 1'b1);
            m_lives--;
            m_state = (m_lives == 0) ? 3 : 0;
            nchecks++;
            if ({lives, game_state, bus.ball_reload, bus.brick_req} !== {2'(m_lives), 2'(m_state), m_lives != 0, 1'b0}) begin
                nerrors++;
                $display("FAIL miss_%0d: lives=%0d state=%0d reload=%b req=%b, want %0d %0d %b 0",
                         k, lives, game_state, bus.ball_reload, bus.brick_req, m_lives, m_state, m_lives != 0);
            end
            @(negedge clk);
            nchecks++;
            if (bus.ball_reload !== 1'b0) begin
                nerrors++;
                $display("FAIL miss_reload_width_%0d: reload=%b, want 0", k, bus.ball_reload);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        nchecks++;
        if (game_state !== 2'd3 || score !== 10'(m_score)) begin
            nerrors++;
            $display("FAIL lost_hold: state=%0d score=%0d, want 3 %0d", game_state, score, m_score);
        end
    endtask

    task automatic test_restart;
        pulse_start;
        m_score = 0; m_lives = LIVES; m_bricks = BRICK_COUNT; m_state = 0;
        nchecks++;
        if ({bus.brick_reload, bus.ball_reload, score, lives, game_state} !== {1'b1, 1'b1, 10'(m_score), 2'(m_lives), 2'(m_state)}) begin
            nerrors++;
            $display("FAIL restart: brel=%b rel=%b score=%0d lives=%0d state=%0d, want 1 1 0 3 0",
                     bus.brick_reload, bus.ball_reload, score, lives, game_state);
        end
        @(negedge clk);
        nchecks++;
        if ({bus.brick_reload, bus.ball_reload, game_state} !== 4'b0000) begin
            nerrors++;
            $display("FAIL restart_pulse_width: brel=%b rel=%b state=%0d, want 0 0 0", bus.brick_reload, bus.ball_reload, game_state);
        end
    endtask

    task automatic test_win;
        int n, k, r, c, d;
        logic h, stepped;
        pulse_start;
        m_state = 1;
        for (int i = 0; i < 400 && m_bricks > 0; i++) begin
            wait_step(n);
            nchecks++;
            if (n !== TICK_DIV) begin
                nerrors++;
                $display("FAIL win_tick_%0d: step after %0d cycles, want %0d", i, n, TICK_DIV);
                break;
            end
            k = $urandom_range(0, 9);
            c = $urandom_range(0, 15);
            if (k < 2) begin
                ball_move($urandom_range(BRICK_ROWS, 15), c, 1'b0);
                nchecks++;
                if (bus.brick_req !== 1'b0) begin
                    nerrors++;
                    $display("FAIL win_no_lookup_%0d: req=%b, want 0", i, bus.brick_req);
                end
            end else begin
                r = $urandom_range(0, BRICK_ROWS - 1);
                ball_move(r, c, 1'b0);
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                nchecks++;
                if ({bus.brick_req, bus.brick_row, bus.brick_col} !== {1'b1, 4'(r), 4'(c)}) begin
                    nerrors++;
                    $display("FAIL win_req_%0d: req=%b row=%0d col=%0d, want 1 %0d %0d", i, bus.brick_req, bus.brick_row, bus.brick_col, r, c);
                end
                h = (k >= 4);
                bus.brick_ack = 1'b1; bus.brick_hit = h;
                @(negedge clk);
                bus.brick_ack = 1'b0; bus.brick_hit = 1'b0;
                if (h) begin
                    m_score  = (m_score < 1023) ? m_score + 1 : 1023;
                    m_bricks = (m_bricks > 0) ? m_bricks - 1 : 0;
                    m_state  = (m_bricks == 0) ? 2 : 1;
                end
                nchecks++;
                if ({score, game_state, bus.brick_req} !== {10'(m_score), 2'(m_state), 1'b0}) begin
                    nerrors++;
                    $display("FAIL win_ack_%0d: score=%0d state=%0d req=%b, want %0d %0d 0", i, score, game_state, bus.brick_req, m_score, m_state);
                end
            end
        end
        nchecks++;
        if (game_state !== 2'd2 || score !== 10'(BRICK_COUNT)) begin
            nerrors++;
            $display("FAIL won: state=%0d score=%0d, want 2 %0d", game_state, score, BRICK_COUNT);
        end
        stepped = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.ball_done = 1'b1; bus.ball_row = 4'(i); bus.ball_miss = i[0];
            bus.brick_ack = 1'b1; bus.brick_hit = 1'b1;
            @(negedge clk);
            stepped |= bus.ball_step | bus.brick_req | bus.ball_reload;
        end
        bus.ball_done = 1'b0; bus.ball_miss = 1'b0; bus.brick_ack = 1'b0; bus.brick_hit = 1'b0;
        @(negedge clk);
        nchecks++;
        if ({game_state, score, lives, stepped} !== {2'd2, 10'(m_score), 2'(m_lives), 1'b0}) begin
            nerrors++;
            $display("FAIL won_hold: state=%0d score=%0d lives=%0d activity=%b, want 2 %0d %0d 0", game_state, score, lives, stepped, m_score, m_lives);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        test_restart;
        pulse_start;
        wait_step(n);
        ball_move(1, 1, 1'b0);
        bus.brick_ack = 1'b1; bus.brick_hit = 1'b1;
        @(negedge clk);
        bus.brick_ack = 1'b0; bus.brick_hit = 1'b0;
        m_score++;
        nchecks++;
        if (score !== 10'(m_score)) begin
            nerrors++;
            $display("FAIL pre_reset_score: score=%0d, want %0d", score, m_score);
        end
        wait_step(n);
        ball_move(3, 7, 1'b0);
        nchecks++;
        if (bus.brick_req !== 1'b1) begin
            nerrors++;
            $display("FAIL pre_reset_req: req=%b, want 1", bus.brick_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nchecks++;
        if ({bus.brick_req, game_state, score, lives, bus.brick_row} !== {1'b0, 2'd0, 10'd0, 2'(LIVES), 4'd0}) begin
            nerrors++;
            $display("FAIL reset_mid: req=%b state=%0d score=%0d lives=%0d row=%0d, want 0 0 0 3 0",
                     bus.brick_req, game_state, score, lives, bus.brick_row);
        end
        bus.brick_ack = 1'b1; bus.brick_hit = 1'b1; bus.ball_done = 1'b1;
        @(negedge clk);
        bus.brick_ack = 1'b0; bus.brick_hit = 1'b0; bus.ball_done = 1'b0;
        @(negedge clk);
        nchecks++;
        if ({score, game_state, bus.brick_req} !== {10'd0, 2'd0, 1'b0}) begin
            nerrors++;
            $display("FAIL late_ack: score=%0d state=%0d req=%b, want 0 0 0", score, game_state, bus.brick_req);
        end
    endtask

    initial begin
        bus.ball_row = '0; bus.ball_col = '0; bus.ball_done = 1'b0; bus.ball_miss = 1'b0;
        bus.brick_ack = 1'b0; bus.brick_hit = 1'b0;
        test_reset;
        test_first_tick;
        test_no_lookup;
        test_miss;
        test_restart;
        test_win;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/brick_game_sequencer.md
Name: brick_game_sequencer

Overview:
Top-level game controller for the brick-breaker datapath. Generates the game tick, steps the ball module once per tick, and runs a req/ack collision lookup against the brick store. Owns score, lives and remaining-brick count, and sequences serve, play, win and lose phases. It sits between the ball-motion module, the brick store and the display/score logic.

Parameters:
TICK_DIV, 25000000, clock cycles per game tick (2 Hz at 50 MHz); the bench uses 4.
LIVES, 3, lives at game start (1..3).
BRICK_ROWS, 7, rows 0..BRICK_ROWS-1 hold bricks.
BRICK_COUNT, 56, bricks at game start (7 rows x 8 bricks).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  serve / new-game request (single-cycle pulse, already debounced)
ball_row  in  4  current ball row index
ball_col  in  4  current ball column index
ball_step  out  1  one-cycle pulse: advance ball one position
ball_done  in  1  ball move complete; ball_row, ball_col and ball_miss are valid in this cycle
ball_miss  in  1  ball fell below the paddle; qualified by ball_done
ball_reload  out  1  one-cycle pulse: return ball to launch position
brick_req  out  1  collision lookup request, held high until ack
brick_row  out  4  row of the lookup, registered from ball_row
brick_col  out  4  column of the lookup, registered from ball_col
brick_ack  in  1  lookup complete; brick_hit is valid in this cycle
brick_hit  in  1  a brick was present and the store cleared it
brick_reload  out  1  one-cycle pulse: restore all bricks
score  out  10  bricks destroyed this game, saturates at 1023
lives  out  2  remaining lives
game_state  out  2  0 SERVE, 1 PLAY, 2 WON, 3 LOST

Behaviour:
- Reset (synchronous, active-high):
  - state = SERVE; score = 0; lives = LIVES; bricks_left = BRICK_COUNT; tick counter = 0.
  - All pulse outputs = 0; brick_req = 0; brick_row = 0; brick_col = 0.
  - Reset asserted mid-handshake drops brick_req at that edge. Late ack/done inputs are then ignored because the FSM is in SERVE.
- Internal FSM states: SERVE, WAIT_TICK, STEP, WAIT_BALL, CHECK, WON, LOST.
  - game_state = 1 for WAIT_TICK, STEP, WAIT_BALL and CHECK.
- SERVE:
  - On start: go to WAIT_TICK and clear the tick counter.
  - No ball_reload is issued here (the ball is already at launch position).
- WAIT_TICK:
  - The counter increments every cycle.
  - When the counter reaches TICK_DIV-1: clear it and go to STEP.
  - Tick-to-tick period while no stalls occur = TICK_DIV + handshake cycles. Ticks are not queued or dropped-counted.
- STEP:
  - Assert ball_step for exactly one cycle, then go to WAIT_BALL.
- WAIT_BALL:
  - Wait indefinitely for ball_done. ball_done is never sampled in the same cycle as ball_step.
  - On ball_done with ball_miss=1:
    - Decrement lives.
    - If lives was 1: lives becomes 0 and go to LOST.
    - Otherwise: pulse ball_reload next cycle and go to SERVE.
    - No brick lookup occurs.
  - On ball_done with ball_miss=0 and ball_row < BRICK_ROWS: latch brick_row/brick_col, raise brick_req, go to CHECK.
  - On ball_done with ball_miss=0 otherwise: return to WAIT_TICK.
- CHECK:
  - brick_req stays high, with stable brick_row/brick_col, until the cycle after brick_ack is sampled high.
  - On ack with brick_hit=1:
    - score += 1, saturating at 1023.
    - bricks_left -= 1, never below 0.
    - If the new bricks_left is 0, go to WON; otherwise go to WAIT_TICK.
  - On ack with brick_hit=0: go to WAIT_TICK.
- WON / LOST:
  - Hold all counters.
  - On start:
    - Pulse brick_reload and ball_reload together (one cycle).
    - score = 0; lives = LIVES; bricks_left = BRICK_COUNT.
    - Go to SERVE. A second start pulse is needed to play.
- start is ignored in every state except SERVE, WON and LOST.
- Spurious ball_done or brick_ack outside their wait states is ignored.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset, TICK_DIV=4, start -> game_state=1. First ball_step pulse lands 4 cycles after entry to WAIT_TICK. score=0, lives=3.
- ball_done with ball_row=2, ball_col=5 -> brick_req=1 with brick_row=2, brick_col=5. Hold ack low for 5 cycles -> req stays high. Then ack with hit=1 -> score=1, req low the next cycle.
- ball_done with ball_row=9 -> no brick_req; the next ball_step follows after TICK_DIV cycles.
- Three ball_miss events -> lives 2, then 1, each with a ball_reload pulse and return to SERVE. The third miss gives lives=0 and game_state=3. start -> brick_reload and ball_reload pulse once, score=0, lives=3, game_state=0.
- Force 56 hits with BRICK_COUNT=56 -> game_state=2 after the 56th ack, score=56. Further ball_done/ack inputs cause no change.
- Assert reset while brick_req=1 -> req=0 at that edge, game_state=0, score=0. A subsequent brick_ack is ignored.
